fetch_stage: RTL and testbench

//  Instruction-fetch stage of the MIPS core. Owns the PC, drives the instruction-memory address,

---
 rtl/fetch_stage_if.sv | 50 +++++
 rtl/fetch_stage.sv | 117 +++++++++++
 tb/tb_fetch_stage.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Bundles the fetch stage's instruction-memory port, the redirect
//             controls coming back from decode, and the IF/ID register outputs.
//             master = fetch stage, slave = memory/decode side.
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_stage_if;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        jump_en;
  logic        jr_en;
  logic [31:0] jr_target;
  logic        branch_taken;
  logic        ifid_valid;
  logic [31:0] ifid_inst;
  logic [31:0] ifid_pcplus4;
  logic        halted;

  modport master (
    output imem_addr,
    input  imem_rdata,
    input  stall,
    input  jump_en,
    input  jr_en,
    input  jr_target,
    input  branch_taken,
    output ifid_valid,
    output ifid_inst,
    output ifid_pcplus4,
    output halted
  );

  modport slave (
    input  imem_addr,
    output imem_rdata,
    output stall,
    output jump_en,
    output jr_en,
    output jr_target,
    output branch_taken,
    input  ifid_valid,
    input  ifid_inst,
    input  ifid_pcplus4,
    input  halted
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : MIPS instruction-fetch stage. Owns the PC, drives the
//             instruction-memory address, applies JR/J/branch redirects
//             resolved in decode, and fills the IF/ID pipeline register.
//             Fetch stops on an all-zero word when HALT_ON_ZERO is set.
//  Config   : define FETCH_TRACE_EN to print a per-fetch trace line and a
//             message on entering HALT (simulation only, no port/timing change).
//  Revision : 1.0  initial release
// ============================================================================
module fetch_stage #(
  parameter logic [31:0] RESET_PC     = 32'h0040_0000,
  parameter bit          HALT_ON_ZERO = 1'b1
) (
  input  wire logic      clock,
  input  wire logic      reset,
  fetch_stage_if.master  bus
);

  localparam logic [0:0] S_RUN  = 1'b0;
  localparam logic [0:0] S_HALT = 1'b1;

  logic [31:0] r_pc;
  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pcplus4;
  logic [0:0]  r_state;

  logic [31:0] w_pcplus4;
  logic [31:0] w_jr_target;
  logic [31:0] w_j_target;
  logic [31:0] w_br_target;
  logic [31:0] w_target;
  logic        w_redirect;
  logic        w_zero_halt;
  logic        w_advance;
  logic        w_unused_jr_lsbs;

  // Next sequential PC and the three candidate redirect targets.
  assign w_pcplus4   = r_pc + 32'd4;
  assign w_jr_target = {bus.jr_target[31:2], 2'b00};
  assign w_j_target  = {r_pcplus4[31:28], r_inst[25:0], 2'b00};
  assign w_br_target = r_pcplus4 + {{14{r_inst[15]}}, r_inst[15:0], 2'b00};

  // JR low bits are simply dropped; there is no alignment fault.
  assign w_unused_jr_lsbs = |bus.jr_target[1:0];

  // Redirects only count when IF/ID holds a real instruction, so the
  // bubble that follows a redirect can never redirect again.
  assign w_redirect  = r_valid & (bus.jr_en | bus.jump_en | bus.branch_taken);
  assign w_zero_halt = HALT_ON_ZERO && (bus.imem_rdata == 32'h0);
  assign w_advance   = (r_state == S_RUN) && !bus.stall;

  // Priority JR > J/JAL > taken branch.
  always_comb begin
    w_target = w_br_target;
    if (bus.jr_en)
      w_target = w_jr_target;
    else if (bus.jump_en)
      w_target = w_j_target;
  end

  // PC, IF/ID register and RUN/HALT state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_valid   <= 1'b0;
      r_inst    <= 32'h0;
      r_pcplus4 <= 32'h0;
      r_state   <= S_RUN;
    end else if (w_advance) begin
      if (w_redirect) begin
        // No delay slot: the word fetched this cycle is squashed.
        r_pc    <= w_target;
        r_valid <= 1'b0;
        r_inst  <= 32'h0;
      end else if (w_zero_halt) begin
        r_state <= S_HALT;
        r_valid <= 1'b0;
      end else begin
        r_inst    <= bus.imem_rdata;
        r_pcplus4 <= w_pcplus4;
        r_valid   <= 1'b1;
        r_pc      <= w_pcplus4;
      end
    end
  end

  assign bus.imem_addr    = r_pc;
  assign bus.ifid_valid   = r_valid;
  assign bus.ifid_inst    = r_inst;
  assign bus.ifid_pcplus4 = r_pcplus4;
  assign bus.halted       = (r_state == S_HALT);

`ifdef FETCH_TRACE_EN
  // Trace each fetch/redirect and the transition into HALT.
  always @(posedge clock) begin
    if (!reset && w_advance) begin
      if (w_redirect && bus.jr_en)
        $display("%0t fetch pc=%08h word=%08h JR", $time, r_pc, bus.imem_rdata);
      else if (w_redirect && bus.jump_en)
        $display("%0t fetch pc=%08h word=%08h J", $time, r_pc, bus.imem_rdata);
      else if (w_redirect)
        $display("%0t fetch pc=%08h word=%08h BR", $time, r_pc, bus.imem_rdata);
      else if (w_zero_halt)
        $display("fetch halted at %08h", r_pc);
      else
        $display("%0t fetch pc=%08h word=%08h SEQ", $time, r_pc, bus.imem_rdata);
    end
  end
`else
  // Trace disabled: no display logic compiled.
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Self-checking bench for fetch_stage: directed scenarios with
//             literal expectations plus randomized redirects/stalls/resets
//             compared every cycle against a behavioural fetch model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_stage;

  logic clock = 1'b0;
  logic reset = 1'b0;

  fetch_stage_if bus ();

  logic [31:0] mem [0:255];

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the architectural fetch state.
  logic [31:0] m_pc    = 32'h0040_0000;
  logic        m_valid = 1'b0;
  logic [31:0] m_inst  = 32'h0;
  logic [31:0] m_p4    = 32'h0;
  logic        m_halt  = 1'b0;
  logic [31:0] m_word;
  logic [31:0] m_tgt;
  int          m_off;

  fetch_stage #(
    .RESET_PC     (32'h0040_0000),
    .HALT_ON_ZERO (1'b1)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  assign bus.imem_rdata = mem[bus.imem_addr[9:2]];

  always #5 clock = ~clock;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one architectural step per rising edge, reset at once.
  initial begin
    forever begin
      @(posedge clock or posedge reset);
      if (reset) begin
        m_pc = 32'h0040_0000; m_valid = 1'b0; m_inst = 32'h0; m_p4 = 32'h0; m_halt = 1'b0;
      end else if (!m_halt && !bus.stall) begin
        m_word = mem[m_pc[9:2]];
        if (m_valid && (bus.jr_en || bus.jump_en || bus.branch_taken)) begin
          if (bus.jr_en)
            m_tgt = bus.jr_target & 32'hFFFF_FFFC;
          else if (bus.jump_en)
            m_tgt = (m_p4 & 32'hF000_0000) | ((m_inst & 32'h03FF_FFFF) << 2);
          else begin
            m_off = int'($signed(m_inst[15:0]));
            m_tgt = m_p4 + 32'(m_off * 4);
          end
          m_pc = m_tgt; m_valid = 1'b0; m_inst = 32'h0;
        end else if (m_word == 32'h0) begin
          m_halt = 1'b1; m_valid = 1'b0;
        end else begin
          m_inst = m_word; m_p4 = m_pc + 32'd4; m_valid = 1'b1; m_pc = m_pc + 32'd4;
        end
      end
    end
  end

  // Compare all outputs against the model away from the active edge.
  initial begin
    forever begin
      @(negedge clock);
      check32("imem_addr",    bus.imem_addr,    m_pc);
      check32("ifid_valid",   {31'h0, bus.ifid_valid}, {31'h0, m_valid});
      check32("ifid_inst",    bus.ifid_inst,    m_inst);
      check32("ifid_pcplus4", bus.ifid_pcplus4, m_p4);
      check32("halted",       {31'h0, bus.halted}, {31'h0, m_halt});
    end
  end

  task automatic drive(input bit s, input bit j, input bit jr, input logic [31:0] jt, input bit br);
    bus.stall = s; bus.jump_en = j; bus.jr_en = jr; bus.jr_target = jt; bus.branch_taken = br;
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  // Asynchronous reset asserted between edges, released on a falling edge.
  task automatic do_reset();
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic fill_default();
    for (int i = 0; i < 256; i++) mem[i] = 32'h2400_0001;
  endtask

  initial begin
    drive(0, 0, 0, 32'h0, 0);
    fill_default();
    #1 reset = 1'b1;

    // Sequential fetch ending on a zero word.
    mem[0] = 32'h2402_000A; mem[1] = 32'h2403_0005; mem[2] = 32'h0043_1020; mem[3] = 32'h0;
    @(negedge clock);
    reset = 1'b0;
    check32("rst_addr", bus.imem_addr, 32'h0040_0000);
    check32("rst_valid", {31'h0, bus.ifid_valid}, 32'h0);
    cyc(); check32("seq1_inst", bus.ifid_inst, 32'h2402_000A);
           check32("seq1_p4", bus.ifid_pcplus4, 32'h0040_0004);
    cyc(); check32("seq2_inst", bus.ifid_inst, 32'h2403_0005);
    cyc(); check32("seq3_inst", bus.ifid_inst, 32'h0043_1020);
           check32("seq3_addr", bus.imem_addr, 32'h0040_000C);
    cyc(); check32("seq4_halted", {31'h0, bus.halted}, 32'h1);
           check32("seq4_valid", {31'h0, bus.ifid_valid}, 32'h0);
    drive(0, 1, 1, 32'h0000_1000, 1);
    cyc(); check32("halt_hold_addr", bus.imem_addr, 32'h0040_000C);
    drive(0, 0, 0, 32'h0, 0);

    // Jump redirect.
    fill_default();
    mem[0] = 32'h0810_0010;
    do_reset();
    cyc(); check32("j_inst", bus.ifid_inst, 32'h0810_0010);
    drive(0, 1, 0, 32'h0, 0);
    cyc(); check32("j_addr", bus.imem_addr, 32'h0040_0040);
           check32("j_bubble", {31'h0, bus.ifid_valid}, 32'h0);
    drive(0, 0, 0, 32'h0, 0);
    cyc(); check32("j_after_valid", {31'h0, bus.ifid_valid}, 32'h1);
           check32("j_after_p4", bus.ifid_pcplus4, 32'h0040_0044);

    // Branch back with a zero word in the fetch slot, then JR priority.
    fill_default();
    mem[3] = 32'h1000_FFFF; mem[4] = 32'h0;
    do_reset();
    repeat (4) cyc();
    check32("br_inst", bus.ifid_inst, 32'h1000_FFFF);
    check32("br_p4", bus.ifid_pcplus4, 32'h0040_0010);
    drive(0, 0, 0, 32'h0, 1);
    cyc(); check32("br_addr", bus.imem_addr, 32'h0040_000C);
           check32("br_zero_nohalt", {31'h0, bus.halted}, 32'h0);
    drive(0, 0, 0, 32'h0, 0);
    cyc(); check32("br_refetch", bus.ifid_inst, 32'h1000_FFFF);
    drive(0, 1, 1, 32'h0040_0023, 1);
    cyc(); check32("jr_prio_addr", bus.imem_addr, 32'h0040_0020);
    drive(0, 0, 0, 32'h0, 0);

    // Stall holds everything and defers the redirect.
    fill_default();
    mem[0] = 32'h0810_0010;
    do_reset();
    cyc();
    drive(1, 1, 0, 32'h0, 0);
    repeat (3) begin
      cyc();
      check32("stall_addr", bus.imem_addr, 32'h0040_0004);
      check32("stall_inst", bus.ifid_inst, 32'h0810_0010);
    end
    drive(0, 1, 0, 32'h0, 0);
    cyc(); check32("stall_rel_addr", bus.imem_addr, 32'h0040_0040);
    drive(0, 0, 0, 32'h0, 0);

    // PC wrap through JR to the top word.
    fill_default();
    do_reset();
    cyc();
    drive(0, 0, 1, 32'hFFFF_FFFF, 0);
    cyc(); check32("wrap_jr_addr", bus.imem_addr, 32'hFFFF_FFFC);
    drive(0, 0, 0, 32'h0, 0);
    cyc(); check32("wrap_addr", bus.imem_addr, 32'h0000_0000);
           check32("wrap_p4", bus.ifid_pcplus4, 32'h0000_0000);

    // Asynchronous reset observed before any clock edge.
    cyc();
    #2 reset = 1'b1;
    #1;
    check32("async_addr", bus.imem_addr, 32'h0040_0000);
    check32("async_valid", {31'h0, bus.ifid_valid}, 32'h0);
    check32("async_halted", {31'h0, bus.halted}, 32'h0);
    @(negedge clock);
    reset = 1'b0;

    // Randomized episodes.
    for (int ep = 0; ep < 40; ep++) begin
      for (int i = 0; i < 256; i++)
        mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : $urandom;
      drive(0, 0, 0, 32'h0, 0);
      do_reset();
      for (int c = 0; c < 60; c++) begin
        drive($urandom_range(0, 3) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 5) == 0, $urandom, $urandom_range(0, 5) == 0);
        cyc();
      end
    end

    drive(0, 0, 0, 32'h0, 0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
